// File: rtl/pwm_dac_if.sv
// rtl/pwm_dac_if.sv - sample stream handshake between the NCO and the PWM/sigma-delta DAC
interface pwm_dac_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - 1-bit PWM / first-order sigma-delta DAC with frame-aligned double-buffered samples
module pwm_dac #(
   parameter int WIDTH = 10
) (
   input  logic    i_clk,
   input  logic    i_rst,
   pwm_dac_if.slave s,
   input  logic    i_mode,
   input  logic    i_clr_ovr,
   output logic    o_pin,
   output logic    o_frame,
   output logic    o_overrun
);
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] act;
   logic [WIDTH-1:0] pend;
   logic             pend_full;
   logic             mode_q;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   acc_next;
   logic             boundary;
   logic             accept;

   assign s.tready = !pend_full;
   assign accept   = s.tvalid && !pend_full;
   assign boundary = (cnt == {WIDTH{1'b1}});
   // Carry out of the low WIDTH bits is the sigma-delta output bit.
   assign acc_next = {1'b0, acc[WIDTH-1:0]} + {1'b0, act};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt       <= '0;
         act       <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
         mode_q    <= 1'b0;
         acc       <= '0;
         o_pin     <= 1'b0;
         o_frame   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         cnt     <= cnt + 1'b1;
         o_frame <= (cnt == '0);

         // A sample taken in the boundary cycle stays in pend for a full frame.
         if (accept) begin
            pend      <= s.tdata;
            pend_full <= 1'b1;
         end else if (boundary && pend_full) begin
            act       <= pend;
            pend_full <= 1'b0;
         end

         if (boundary) begin
            mode_q <= i_mode;
         end

         if (mode_q) begin
            o_pin <= acc_next[WIDTH];
            acc   <= acc_next;
         end else begin
            o_pin <= (cnt < act);
         end

         if (boundary && (i_mode != mode_q)) begin
            acc <= '0;
         end

         if (s.tvalid && pend_full) begin
            o_overrun <= 1'b1;
         end else if (i_clr_ovr) begin
            o_overrun <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pwm_dac.sv
// tb/tb_pwm_dac.sv - directed self-checking bench for pwm_dac
module tb_pwm_dac;
   localparam int W = 10;
   localparam int N = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_mode = 1'b0;
   logic i_clr_ovr = 1'b0;
   logic o_pin, o_frame, o_overrun;

   pwm_dac_if #(.WIDTH(W)) s_if ();

   pwm_dac #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .s         (s_if.slave),
      .i_mode    (i_mode),
      .i_clr_ovr (i_clr_ovr),
      .o_pin     (o_pin),
      .o_frame   (o_frame),
      .o_overrun (o_overrun)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [N-1:0] bits;
   int highs;
   int nfr;
   logic fr0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_ph(input int p);
      for (int i = 0; i < N && (cyc % N) != p; i++) tick();
   endtask

   // Collects one frame of output; expects to start with the counter at 0.
   task automatic measure_frame();
      highs = 0;
      nfr = 0;
      fr0 = 1'b0;
      for (int i = 0; i < N; i++) begin
         tick();
         bits[i] = o_pin;
         highs += int'(o_pin);
         if (o_frame) nfr++;
         if (i == 0) fr0 = o_frame;
      end
   endtask

   task automatic test_reset();
      s_if.tdata = '0;
      s_if.tvalid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (o_pin !== 1'b0) begin errors++; $display("FAIL rst_pin got %b exp 0", o_pin); end
      checks++; if (o_frame !== 1'b0) begin errors++; $display("FAIL rst_frame got %b exp 0", o_frame); end
      checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", o_overrun); end
      checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", s_if.tready); end
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_idle();
      for (int f = 0; f < 2; f++) begin
         measure_frame();
         checks++; if (highs != 0) begin errors++; $display("FAIL idle_highs got %0d exp 0", highs); end
         checks++; if (nfr != 1 || fr0 !== 1'b1) begin errors++; $display("FAIL idle_frame got cnt %0d first %b exp 1 1", nfr, fr0); end
      end
      checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", s_if.tready); end
      checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL idle_ovr got %b exp 0", o_overrun); end
   endtask

   task automatic test_pwm_132();
      wait_ph(10);
      s_if.tdata = 10'd132;
      s_if.tvalid = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL pwm_ready_drop got %b exp 0", s_if.tready); end
      wait_ph(1023);
      checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL pwm_ready_hold got %b exp 0", s_if.tready); end
      tick();
      checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL pwm_ready_rise got %b exp 1", s_if.tready); end
      for (int f = 0; f < 2; f++) begin
         measure_frame();
         checks++; if (highs != 132) begin errors++; $display("FAIL pwm132_highs got %0d exp 132", highs); end
         checks++; if (bits[0] !== 1'b1 || bits[131] !== 1'b1 || bits[132] !== 1'b0) begin
            errors++; $display("FAIL pwm132_edges got %b%b%b exp 110", bits[0], bits[131], bits[132]); end
         checks++; if (fr0 !== 1'b1 || nfr != 1) begin errors++; $display("FAIL pwm132_frame got %b %0d exp 1 1", fr0, nfr); end
      end
   endtask

   task automatic test_extremes();
      wait_ph(10);
      s_if.tdata = 10'd0;
      s_if.tvalid = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      wait_ph(0);
      measure_frame();
      checks++; if (highs != 0) begin errors++; $display("FAIL ext0_highs got %0d exp 0", highs); end
      wait_ph(10);
      s_if.tdata = 10'd1023;
      s_if.tvalid = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      wait_ph(0);
      measure_frame();
      checks++; if (highs != 1023) begin errors++; $display("FAIL ext1023_highs got %0d exp 1023", highs); end
      checks++; if (bits[1022] !== 1'b1 || bits[1023] !== 1'b0) begin
         errors++; $display("FAIL ext1023_wrap got %b%b exp 10", bits[1022], bits[1023]); end
   endtask

   task automatic test_handshake();
      wait_ph(10);
      s_if.tdata = 10'd100;
      s_if.tvalid = 1'b1;
      tick();
      checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL hs_ready_low got %b exp 0", s_if.tready); end
      s_if.tdata = 10'd200;
      tick();
      checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL hs_ovr_set got %b exp 1", o_overrun); end
      wait_ph(0);
      checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL hs_ready_ret got %b exp 1", s_if.tready); end
      measure_frame();
      checks++; if (highs != 100) begin errors++; $display("FAIL hs_act100 got %0d exp 100", highs); end
      s_if.tdata = 10'd300;
      measure_frame();
      checks++; if (highs != 200) begin errors++; $display("FAIL hs_act200 got %0d exp 200", highs); end
      s_if.tvalid = 1'b0;
      checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL hs_ovr_sticky got %b exp 1", o_overrun); end
      i_clr_ovr = 1'b1;
      tick();
      i_clr_ovr = 1'b0;
      checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL hs_ovr_clr got %b exp 0", o_overrun); end
      s_if.tdata = 10'd400;
      s_if.tvalid = 1'b1;
      tick();
      s_if.tdata = 10'd999;
      i_clr_ovr = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      i_clr_ovr = 1'b0;
      checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL hs_set_wins got %b exp 1", o_overrun); end
      wait_ph(0);
      measure_frame();
      checks++; if (highs != 400) begin errors++; $display("FAIL hs_act400 got %0d exp 400", highs); end
   endtask

   task automatic test_sigma_delta();
      int bad;
      wait_ph(10);
      s_if.tdata = 10'd512;
      s_if.tvalid = 1'b1;
      i_mode = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      wait_ph(0);
      measure_frame();
      bad = 0;
      for (int i = 0; i < N; i++) if (bits[i] !== ((i % 2) == 1)) bad++;
      checks++; if (highs != 512) begin errors++; $display("FAIL sd512_highs got %0d exp 512", highs); end
      checks++; if (bad != 0) begin errors++; $display("FAIL sd512_pattern got %0d bad cycles exp 0", bad); end
      checks++; if (fr0 !== 1'b1) begin errors++; $display("FAIL sd512_frame got %b exp 1", fr0); end
      wait_ph(10);
      s_if.tdata = 10'd256;
      s_if.tvalid = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      wait_ph(0);
      measure_frame();
      bad = 0;
      for (int i = 0; i < N; i++) if (bits[i] !== ((i % 4) == 3)) bad++;
      checks++; if (highs != 256) begin errors++; $display("FAIL sd256_highs got %0d exp 256", highs); end
      checks++; if (bad != 0) begin errors++; $display("FAIL sd256_pattern got %0d bad cycles exp 0", bad); end
   endtask

   task automatic test_reset_mid();
      wait_ph(10);
      s_if.tdata = 10'd132;
      s_if.tvalid = 1'b1;
      i_mode = 1'b0;
      tick();
      s_if.tvalid = 1'b0;
      wait_ph(0);
      measure_frame();
      checks++; if (highs != 132) begin errors++; $display("FAIL rm_pwm_back got %0d exp 132", highs); end
      wait_ph(10);
      s_if.tdata = 10'd777;
      s_if.tvalid = 1'b1;
      tick();
      s_if.tdata = 10'd5;
      tick();
      s_if.tvalid = 1'b0;
      wait_ph(500);
      checks++; if (s_if.tready !== 1'b0 || o_overrun !== 1'b1) begin
         errors++; $display("FAIL rm_pre got ready %b ovr %b exp 0 1", s_if.tready, o_overrun); end
      rst = 1'b1;
      #2;
      checks++; if (o_pin !== 1'b0 || o_frame !== 1'b0) begin
         errors++; $display("FAIL rm_async_out got pin %b frame %b exp 0 0", o_pin, o_frame); end
      checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rm_async_ovr got %b exp 0", o_overrun); end
      checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rm_async_ready got %b exp 1", s_if.tready); end
      tick();
      rst = 1'b0;
      cyc = 0;
      for (int f = 0; f < 2; f++) begin
         measure_frame();
         checks++; if (highs != 0) begin errors++; $display("FAIL rm_after_highs got %0d exp 0", highs); end
         checks++; if (fr0 !== 1'b1 || nfr != 1) begin errors++; $display("FAIL rm_after_frame got %b %0d exp 1 1", fr0, nfr); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_pwm_132();
      test_extremes();
      test_handshake();
      test_sigma_delta();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
